// File: rtl/regfile_writeback_unit_if.sv
// Bundle of writeback-side signals: ALU result, long-latency handshake,
// scoreboard alloc/query and the register-file write port.
interface regfile_writeback_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lres_valid;
  logic        lres_ready;
  logic [4:0]  lres_rd;
  logic [31:0] lres_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [4:0]  rd_query;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic        stall_req;
  logic [5:0]  busy_count;
  logic [4:0]  rd_index;
  logic [31:0] rd_reg_content;

  modport master (
    output alu_valid, alu_rd, alu_data, lres_valid, lres_rd, lres_data,
           alloc_valid, alloc_rd, rs1_index, rs2_index, rd_query,
    input  lres_ready, rs1_busy, rs2_busy, rd_busy, stall_req, busy_count,
           rd_index, rd_reg_content
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lres_valid, lres_rd, lres_data,
           alloc_valid, alloc_rd, rs1_index, rs2_index, rd_query,
    output lres_ready, rs1_busy, rs2_busy, rd_busy, stall_req, busy_count,
           rd_index, rd_reg_content
  );
endinterface

// File: rtl/regfile_writeback_unit.sv
// Merges ALU and handshaked long-latency results into one registered register
// file write stream; tracks pending long-latency destinations in a scoreboard.
module regfile_writeback_unit #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                     clk,
  input logic                     rst,
  regfile_writeback_unit_if.slave wb
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [4:0]    rd_index_q, rd_index_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          hold_valid_q, hold_valid_d;
  logic [4:0]    hold_rd_q, hold_rd_d;
  logic [31:0]   hold_data_q, hold_data_d;
  logic [31:0]   busy_q, busy_d;
  logic [5:0]    count_q, count_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic alu_wr, drain, accept, set_req, clr_eff, set_eff;

  always_comb begin
    alu_wr  = wb.alu_valid && (wb.alu_rd != '0);
    drain   = hold_valid_q && !alu_wr;
    accept  = wb.lres_valid && !hold_valid_q;
    set_req = wb.alloc_valid && (wb.alloc_rd != '0);
    // Count only real bit transitions so busy_count always equals popcount.
    clr_eff = drain && busy_q[hold_rd_q];
    set_eff = set_req && (!busy_q[wb.alloc_rd] || (clr_eff && (hold_rd_q == wb.alloc_rd)));

    rd_index_d   = '0;
    rd_data_d    = rd_data_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    busy_d       = busy_q;
    starve_d     = starve_q;
    stall_d      = stall_q;

    if (alu_wr) begin
      rd_index_d = wb.alu_rd;
      rd_data_d  = wb.alu_data;
    end else if (hold_valid_q) begin
      rd_index_d = hold_rd_q;
      rd_data_d  = hold_data_q;
    end

    if (drain) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = wb.lres_rd;
      hold_data_d  = wb.lres_data;
    end

    if (drain) busy_d[hold_rd_q] = 1'b0;
    if (set_req) busy_d[wb.alloc_rd] = 1'b1;
    busy_d[0] = 1'b0;
    count_d = count_q + 6'(set_eff) - 6'(clr_eff);

    if (drain) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else if (hold_valid_q && alu_wr) begin
      if (starve_q != CW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
      if (starve_d == CW'(STARVE_MAX)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_index_q   <= '0;
      rd_data_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      busy_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      stall_q      <= 1'b0;
    end else begin
      rd_index_q   <= rd_index_d;
      rd_data_q    <= rd_data_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      stall_q      <= stall_d;
    end
  end

  assign wb.lres_ready     = !hold_valid_q;
  assign wb.rs1_busy       = busy_q[wb.rs1_index];
  assign wb.rs2_busy       = busy_q[wb.rs2_index];
  assign wb.rd_busy        = busy_q[wb.rd_query];
  assign wb.stall_req      = stall_q;
  assign wb.busy_count     = count_q;
  assign wb.rd_index       = rd_index_q;
  assign wb.rd_reg_content = rd_data_q;

endmodule
